// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: three per-source result FIFOs feeding the two
// physical-regfile write ports, granted round-robin up to two per cycle.
module int_wb_arbiter #(
  parameter int PREG_W = 6,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [PREG_W-1:0] src0_idx,
  input  logic [63:0]       src0_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic [PREG_W-1:0] src1_idx,
  input  logic [63:0]       src1_data,
  input  logic              src2_valid,
  output logic              src2_ready,
  input  logic [PREG_W-1:0] src2_idx,
  input  logic [63:0]       src2_data,
  output logic              write0_en,
  output logic [PREG_W-1:0] write0_idx,
  output logic [63:0]       write0_data,
  output logic              write1_en,
  output logic [PREG_W-1:0] write1_idx,
  output logic [63:0]       write1_data,
  output logic              wb_idle
);

  localparam int DATA_W = 64;
  localparam int NSRC   = 3;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [NSRC-1:0]   src_valid;
  logic [NSRC-1:0]   src_ready;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic [NSRC-1:0]   cand;
  logic [PREG_W-1:0] src_idx   [NSRC];
  logic [DATA_W-1:0] src_data  [NSRC];

  logic [PREG_W-1:0] idx_mem   [NSRC][DEPTH];
  logic [DATA_W-1:0] data_mem  [NSRC][DEPTH];
  logic [PTR_W-1:0]  rd_ptr    [NSRC];
  logic [PTR_W-1:0]  wr_ptr    [NSRC];
  logic [CNT_W-1:0]  count     [NSRC];
  logic [PREG_W-1:0] head_idx  [NSRC];
  logic [DATA_W-1:0] head_data [NSRC];

  logic [1:0]        rr;
  logic [1:0]        scan [NSRC];
  logic              g0_vld;
  logic              g1_vld;
  logic [1:0]        g0_src;
  logic [1:0]        g1_src;

  function automatic logic [1:0] rr_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign src_valid   = {src2_valid, src1_valid, src0_valid};
  assign src_idx[0]  = src0_idx;
  assign src_idx[1]  = src1_idx;
  assign src_idx[2]  = src2_idx;
  assign src_data[0] = src0_data;
  assign src_data[1] = src1_data;
  assign src_data[2] = src2_data;
  assign src0_ready  = src_ready[0];
  assign src1_ready  = src_ready[1];
  assign src2_ready  = src_ready[2];

  // Ready and idle come from registered counts only, never from this cycle's pop.
  always_comb begin
    wb_idle = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      src_ready[k] = (count[k] < FULL);
      cand[k]      = (count[k] != '0);
      push[k]      = src_valid[k] && src_ready[k] && (src_idx[k] != '0);
      head_idx[k]  = idx_mem[k][rd_ptr[k]];
      head_data[k] = data_mem[k][rd_ptr[k]];
      if (count[k] != '0) wb_idle = 1'b0;
    end
  end

  // Port 1 skips any head that would write the same preg as port 0 this cycle.
  always_comb begin
    scan[0] = rr;
    scan[1] = rr_inc(rr);
    scan[2] = rr_inc(scan[1]);
    g0_vld  = 1'b0;
    g0_src  = 2'd0;
    g1_vld  = 1'b0;
    g1_src  = 2'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (cand[scan[i]]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_src = scan[i];
        end else if (!g1_vld && (head_idx[scan[i]] != head_idx[g0_src])) begin
          g1_vld = 1'b1;
          g1_src = scan[i];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      pop[k] = (g0_vld && (g0_src == 2'(k))) || (g1_vld && (g1_src == 2'(k)));
    end
  end

  assign write0_en   = g0_vld;
  assign write0_idx  = g0_vld ? head_idx[g0_src]  : '0;
  assign write0_data = g0_vld ? head_data[g0_src] : '0;
  assign write1_en   = g1_vld;
  assign write1_idx  = g1_vld ? head_idx[g1_src]  : '0;
  assign write1_data = g1_vld ? head_data[g1_src] : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr <= 2'd0;
      for (int k = 0; k < NSRC; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      if (g0_vld) rr <= rr_inc(g1_vld ? g1_src : g0_src);
      for (int k = 0; k < NSRC; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + CNT_W'(1);
          2'b01:   count[k] <= count[k] - CNT_W'(1);
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  // Storage is not reset; stale entries are unreachable once the counts clear.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NSRC; k++) begin
      if (push[k]) begin
        idx_mem[k][wr_ptr[k]]  <= src_idx[k];
        data_mem[k][wr_ptr[k]] <= src_data[k];
      end
    end
  end

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Bench for int_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the writeback rules.
module tb_int_wb_arbiter;

  localparam int PREG_W = 6;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [PREG_W-1:0] idx;
    logic [63:0]       data;
  } ent_t;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        v = '0;
  logic [PREG_W-1:0] sidx [3];
  logic [63:0]       sdat [3];
  logic              r0, r1, r2;
  logic              w0_en, w1_en, idle;
  logic [PREG_W-1:0] w0_idx, w1_idx;
  logic [63:0]       w0_data, w1_data;

  int   checks = 0;
  int   errors = 0;
  ent_t mq [3][$];
  int   rr_m = 0;
  bit   acc [3];

  always #5 clock = ~clock;

  int_wb_arbiter #(.PREG_W(PREG_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .src0_valid(v[0]), .src0_ready(r0), .src0_idx(sidx[0]), .src0_data(sdat[0]),
    .src1_valid(v[1]), .src1_ready(r1), .src1_idx(sidx[1]), .src1_data(sdat[1]),
    .src2_valid(v[2]), .src2_ready(r2), .src2_idx(sidx[2]), .src2_data(sdat[2]),
    .write0_en(w0_en), .write0_idx(w0_idx), .write0_data(w0_data),
    .write1_en(w1_en), .write1_idx(w1_idx), .write1_data(w1_data),
    .wb_idle(idle)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    v = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      acc[k] = 1'b0;
    end
    rr_m = 0;
  endtask

  // One cycle: compare DUT against the model at the falling edge, then advance
  // the model with whatever the rising edge will accept and write.
  task automatic step();
    int g0, g1, s, last;
    logic [2:0] rdy;
    logic [PREG_W-1:0] e_idx0, e_idx1;
    logic [63:0] e_dat0, e_dat1;
    bit all_empty;
    @(negedge clock);
    rdy = {r2, r1, r0};
    g0 = -1;
    g1 = -1;
    for (int i = 0; i < 3; i++) begin
      s = (rr_m + i) % 3;
      if (mq[s].size() != 0) begin
        if (g0 < 0) g0 = s;
        else if (g1 < 0 && mq[s][0].idx != mq[g0][0].idx) g1 = s;
      end
    end
    e_idx0 = '0; e_dat0 = '0; e_idx1 = '0; e_dat1 = '0;
    if (g0 >= 0) begin e_idx0 = mq[g0][0].idx; e_dat0 = mq[g0][0].data; end
    if (g1 >= 0) begin e_idx1 = mq[g1][0].idx; e_dat1 = mq[g1][0].data; end
    all_empty = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ready%0d", k), rdy[k], mq[k].size() < DEPTH);
      if (mq[k].size() != 0) all_empty = 1'b0;
    end
    chk("wb_idle", idle, all_empty);
    chk("w0_en", w0_en, g0 >= 0);
    chk("w0_idx", w0_idx, e_idx0);
    chk("w0_data", w0_data, e_dat0);
    chk("w1_en", w1_en, g1 >= 0);
    chk("w1_idx", w1_idx, e_idx1);
    chk("w1_data", w1_data, e_dat1);
    for (int k = 0; k < 3; k++) acc[k] = v[k] && (mq[k].size() < DEPTH);
    if (g0 >= 0) void'(mq[g0].pop_front());
    if (g1 >= 0) void'(mq[g1].pop_front());
    if (g0 >= 0) begin
      last = (g1 >= 0) ? g1 : g0;
      rr_m = (last + 1) % 3;
    end
    for (int k = 0; k < 3; k++) begin
      if (acc[k] && sidx[k] != '0) mq[k].push_back('{idx: sidx[k], data: sdat[k]});
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      sidx[k] = '0;
      sdat[k] = '0;
      acc[k]  = 1'b0;
    end

    do_reset();
    repeat (3) step();

    // single push from src0
    v[0] = 1'b1; sidx[0] = 6'd5; sdat[0] = 64'hAA;
    step();
    v = '0;
    chk("single_en", w0_en, 1'b1);
    chk("single_idx", w0_idx, 64'd5);
    chk("single_data", w0_data, 64'hAA);
    chk("single_w1", w1_en, 1'b0);
    step();
    chk("single_idle", idle, 1'b1);

    // all three sources at once from rr=0
    do_reset();
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b1; sidx[k] = 6'(k + 1); sdat[k] = 64'h100 + 64'(k);
    end
    step();
    v = '0;
    chk("tri_w0_idx", w0_idx, 64'd1);
    chk("tri_w1_idx", w1_idx, 64'd2);
    step();
    chk("tri2_w0_idx", w0_idx, 64'd3);
    chk("tri2_w1_en", w1_en, 1'b0);
    step();

    // preg 0 dropped
    v[1] = 1'b1; sidx[1] = 6'd0; sdat[1] = 64'h55;
    step();
    v = '0;
    chk("p0_idle", idle, 1'b1);
    chk("p0_w0_en", w0_en, 1'b0);
    step();

    // same destination on two heads
    do_reset();
    v[0] = 1'b1; sidx[0] = 6'd7; sdat[0] = 64'hD0;
    v[1] = 1'b1; sidx[1] = 6'd7; sdat[1] = 64'hD1;
    step();
    v = '0;
    chk("dup_w0_data", w0_data, 64'hD0);
    chk("dup_w1_en", w1_en, 1'b0);
    step();
    chk("dup2_w0_data", w0_data, 64'hD1);
    chk("dup2_w1_en", w1_en, 1'b0);
    step();

    // src2 fills while deferred, then reset discards it
    do_reset();
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b1; sidx[k] = 6'(k + 1); sdat[k] = 64'h200 + 64'(k);
    end
    repeat (2) step();
    v = '0;
    chk("fill_ready2", r2, 1'b0);
    do_reset();
    chk("rst_ready2", r2, 1'b1);
    chk("rst_w0_en", w0_en, 1'b0);
    chk("rst_w1_en", w1_en, 1'b0);
    repeat (3) step();

    // randomized traffic with occasional mid-run resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      for (int k = 0; k < 3; k++) begin
        if (!v[k] || acc[k]) begin
          v[k]    = ($urandom_range(0, 9) < 7);
          sidx[k] = (c < 2000) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
          sdat[k] = {$urandom, $urandom};
        end
      end
      step();
    end
    v = '0;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
